// File: rtl/fir_pkg.sv
// Shared types for the FIR sample feeder: sample word, FIFO entry and
// feeder state encoding.
package fir_pkg;

  typedef logic [31:0] sample_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;

  typedef struct packed {
    logic    last;
    sample_t data;
  } fifo_entry_t;

  localparam sample_t ZERO_SAMPLE = '0;

endpackage

// File: rtl/fir_sample_fifo.sv
// Sample FIFO (data + end-of-stream flag) with array storage, pointer-based
// occupancy and a running count of last-marked entries still queued.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output sample_t     head_data,
  output logic        full,
  output logic        empty,
  output logic        has_last
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  fifo_entry_t   head_entry;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   last_cnt_reg;
  logic          do_push;
  logic          do_pop;
  logic          push_last;
  logic          pop_last;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_entry = mem[rd_ptr_reg];
  assign head_data = head_entry.data;
  assign push_last = do_push && push_entry.last;
  assign pop_last  = do_pop && head_entry.last;
  assign has_last  = (last_cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      last_cnt_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      case ({push_last, pop_last})
        2'b10:   last_cnt_reg <= last_cnt_reg + (AW+1)'(1);
        2'b01:   last_cnt_reg <= last_cnt_reg - (AW+1)'(1);
        default: last_cnt_reg <= last_cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered float32 samples to the FIR on each request edge, primes it out
// of reset with the first sample, then signals stop and supplies flush zeros.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int FLUSH_LEN = 7,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [31:0]      wr_data,
  input  logic             wr_last,
  output logic             wr_ready,
  input  logic             start,
  input  logic             fir_next,
  output logic [31:0]      fir_in,
  output logic             fir_rst,
  output logic             fir_stop,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  feeder_state_t    state_reg;
  feeder_state_t    state_next;
  logic             next_prev_reg;
  logic             alive_reg;
  logic             eos_seen_reg;
  logic [FW-1:0]    flush_cnt_reg;
  sample_t          fir_in_reg;
  logic             fir_rst_reg;
  logic             fir_stop_reg;
  logic             underrun_reg;
  logic [CNT_W-1:0] sent_cnt_reg;

  logic             req;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             has_last;
  sample_t          head_data;
  fifo_entry_t      push_entry;
  logic             flush_last;

  assign req        = fir_next && !next_prev_reg;
  // Held low until the first clock after reset so the host never writes during reset.
  assign wr_ready   = alive_reg && !full;
  assign push       = wr_valid && wr_ready;
  assign push_entry = '{last: wr_last, data: wr_data};
  assign flush_last = (flush_cnt_reg == FW'(FLUSH_LEN - 1));

  fir_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .has_last  (has_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = PRIME;
      end
      PRIME: begin
        if (!empty) state_next = RUN;
        else if (eos_seen_reg) state_next = DONE;
      end
      RUN: begin
        if (req && empty && eos_seen_reg) state_next = DRAIN;
      end
      DRAIN: begin
        if (req && flush_last) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = PRIME;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      PRIME: begin
        busy = 1'b1;
        pop  = !empty;
      end
      RUN: begin
        busy = 1'b1;
        pop  = req && !empty;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_prev_reg <= 1'b0;
      alive_reg     <= 1'b0;
      eos_seen_reg  <= 1'b0;
      flush_cnt_reg <= '0;
      fir_in_reg    <= ZERO_SAMPLE;
      fir_rst_reg   <= 1'b1;
      fir_stop_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      sent_cnt_reg  <= '0;
    end else begin
      next_prev_reg <= fir_next;
      alive_reg     <= 1'b1;
      if (push && wr_last) begin
        eos_seen_reg <= 1'b1;
      end
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            // Keep end-of-stream only when a last-marked sample is still queued.
            eos_seen_reg <= has_last || (push && wr_last);
            fir_stop_reg <= 1'b0;
            fir_rst_reg  <= 1'b1;
            sent_cnt_reg <= '0;
            underrun_reg <= 1'b0;
          end
        end
        PRIME: begin
          if (!empty) begin
            fir_in_reg   <= head_data;
            fir_rst_reg  <= 1'b0;
            sent_cnt_reg <= CNT_W'(1);
          end
        end
        RUN: begin
          if (req) begin
            if (!empty) begin
              fir_in_reg <= head_data;
              if (sent_cnt_reg != '1) begin
                sent_cnt_reg <= sent_cnt_reg + CNT_W'(1);
              end
            end else if (!eos_seen_reg) begin
              fir_in_reg   <= ZERO_SAMPLE;
              underrun_reg <= 1'b1;
            end else begin
              fir_in_reg    <= ZERO_SAMPLE;
              fir_stop_reg  <= 1'b1;
              flush_cnt_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (req) begin
            fir_in_reg    <= ZERO_SAMPLE;
            flush_cnt_reg <= flush_cnt_reg + FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fir_in   = fir_in_reg;
  assign fir_rst  = fir_rst_reg;
  assign fir_stop = fir_stop_reg;
  assign underrun = underrun_reg;
  assign sent_cnt = sent_cnt_reg;

endmodule
